// File: rtl/falafel_pkg.sv
// falafel_pkg: shared types and default constants for the falafel header LSU.
//   lsu_op_e     : core operation codes (LOCK..DELETE; codes above DELETE are illegal)
//   lsu_status_e : response status codes
//   lsu_state_e  : LSU state encoding, also exported on the debug state port
//   EMPTY_KEY_DEFAULT, NEXT_ADDR_OFFSET_DEFAULT : default parameter values
package falafel_pkg;

    typedef enum logic [2:0] {
        OP_LOCK   = 3'd0,
        OP_UNLOCK = 3'd1,
        OP_LOAD   = 3'd2,
        OP_INSERT = 3'd3,
        OP_DELETE = 3'd4
    } lsu_op_e;

    typedef enum logic [1:0] {
        STATUS_OK         = 2'd0,
        STATUS_LOCK_FAIL  = 2'd1,
        STATUS_ILLEGAL_OP = 2'd2
    } lsu_status_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_BACKOFF = 3'd3,
        S_RSP     = 3'd4
    } lsu_state_e;

    localparam logic [63:0] EMPTY_KEY_DEFAULT        = 64'd0;
    localparam logic [63:0] NEXT_ADDR_OFFSET_DEFAULT = 64'd8;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

// File: rtl/falafel_lsu_backoff.sv
// falafel_lsu_backoff: lock retry counter and backoff timer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart counting (pulsed when a new request is captured)
//   fail_i        : one pulse per failed lock attempt; also starts the backoff
//   done_o        : backoff interval has elapsed
//   limit_hit_o   : the next failed attempt reaches MAX_RETRY (never when 0)
// Optional feature macro FALAFEL_LSU_BACKOFF_EN: exponential backoff of
// 2^min(retry_cnt-1, BACKOFF_MAX_LOG2) cycles. Without it the backoff is a
// single cycle and no timer is built.
module falafel_lsu_backoff
    import falafel_pkg::*;
#(
    parameter int unsigned MAX_RETRY        = 16,
    parameter int unsigned BACKOFF_MAX_LOG2 = 6
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic fail_i,
    output logic done_o,
    output logic limit_hit_o
);

    logic [31:0] retry_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retry_cnt_q <= '0;
        end else if (clear_i) begin
            retry_cnt_q <= '0;
        end else if (fail_i && (retry_cnt_q != '1)) begin
            retry_cnt_q <= retry_cnt_q + 32'd1;
        end
    end

    // Looks one failure ahead so the FSM can pick RSP or BACKOFF in the same
    // cycle it sees the failure, without a combinational loop through fail_i.
    assign limit_hit_o = (MAX_RETRY != 0) && ((retry_cnt_q + 32'd1) == MAX_RETRY);

`ifdef FALAFEL_LSU_BACKOFF_EN
    localparam int unsigned TW = BACKOFF_MAX_LOG2 + 1;

    logic [TW-1:0] timer_q;
    logic [31:0]   shift_k;

    // retry_cnt_q still holds the pre-failure count here, i.e. retry_cnt-1.
    assign shift_k = (retry_cnt_q > BACKOFF_MAX_LOG2) ? BACKOFF_MAX_LOG2 : retry_cnt_q;

    // The timer is loaded with interval-1 and BACKOFF exits once it reads 0,
    // so the FSM spends exactly 2^k cycles in BACKOFF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (clear_i) begin
            timer_q <= '0;
        end else if (fail_i) begin
            timer_q <= (TW'(1) << shift_k) - TW'(1);
        end else if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
        end
    end

    assign done_o = (timer_q == '0);
`else
    logic [31:0] unused_backoff_log2;
    assign unused_backoff_log2 = BACKOFF_MAX_LOG2;
    assign done_o = 1'b1;
`endif

endmodule

// File: rtl/falafel_hdr_lsu.sv
// falafel_hdr_lsu: header load/store unit of the falafel allocator.
// Serves one LOCK / UNLOCK / LOAD / INSERT / DELETE at a time by issuing
// single-word reads, writes and compare-and-swaps to memory.
//   core_req_* : request from the core (valid/ready), op, addr, size, next_addr
//   core_rsp_* : response to the core (valid/ready), addr echo, loaded fields, status
//   mem_req_*  : memory request (valid/ready), write/CAS flags, addr, data, CAS expected
//   mem_rsp_*  : memory response (valid/ready), read data or CAS old word
//   dbg_state_o: current FSM state, for observation only
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the clock edge; once raised, valid and its payload stay stable
// until that transfer.
// Optional feature macro FALAFEL_LSU_BACKOFF_EN (see falafel_lsu_backoff).
module falafel_hdr_lsu
    import falafel_pkg::*;
#(
    parameter int unsigned       DATA_W           = 64,
    parameter logic [DATA_W-1:0] NEXT_ADDR_OFFSET = DATA_W'(NEXT_ADDR_OFFSET_DEFAULT),
    parameter logic [DATA_W-1:0] LOCK_ADDR        = '0,
    parameter logic [DATA_W-1:0] LOCK_ID          = DATA_W'(1),
    parameter logic [DATA_W-1:0] EMPTY_KEY        = DATA_W'(EMPTY_KEY_DEFAULT),
    parameter int unsigned       MAX_RETRY        = 16,
    parameter int unsigned       BACKOFF_MAX_LOG2 = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_val_i,
    output logic              core_req_rdy_o,
    input  logic [2:0]        core_req_op_i,
    input  logic [DATA_W-1:0] core_req_addr_i,
    input  logic [DATA_W-1:0] core_req_size_i,
    input  logic [DATA_W-1:0] core_req_next_addr_i,
    output logic              core_rsp_val_o,
    input  logic              core_rsp_rdy_i,
    output logic [DATA_W-1:0] core_rsp_addr_o,
    output logic [DATA_W-1:0] core_rsp_size_o,
    output logic [DATA_W-1:0] core_rsp_next_addr_o,
    output logic [1:0]        core_rsp_status_o,
    output logic              mem_req_val_o,
    input  logic              mem_req_rdy_i,
    output logic              mem_req_is_write_o,
    output logic              mem_req_is_cas_o,
    output logic [DATA_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_data_o,
    output logic [DATA_W-1:0] mem_req_cas_exp_o,
    input  logic              mem_rsp_val_i,
    output logic              mem_rsp_rdy_o,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output lsu_state_e        dbg_state_o
);

    lsu_state_e        state_q, state_d;
    lsu_status_e       status_q, status_d;
    lsu_op_e           op_q;
    logic              step_q, step_d;
    logic [DATA_W-1:0] addr_q, req_size_q, req_next_q, ld_size_q, ld_next_q;
    logic              accept, fail, ld_size_en, ld_next_en;
    logic              backoff_done, limit_hit;

    assign accept = (state_q == S_IDLE) && core_req_val_i;

    falafel_lsu_backoff #(
        .MAX_RETRY       (MAX_RETRY),
        .BACKOFF_MAX_LOG2(BACKOFF_MAX_LOG2)
    ) u_backoff (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (accept),
        .fail_i     (fail),
        .done_o     (backoff_done),
        .limit_hit_o(limit_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            status_q   <= STATUS_OK;
            op_q       <= OP_LOCK;
            step_q     <= 1'b0;
            addr_q     <= '0;
            req_size_q <= '0;
            req_next_q <= '0;
            ld_size_q  <= '0;
            ld_next_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            step_q   <= step_d;
            if (accept) begin
                op_q       <= lsu_op_e'(core_req_op_i);
                addr_q     <= core_req_addr_i;
                req_size_q <= core_req_size_i;
                req_next_q <= core_req_next_addr_i;
                ld_size_q  <= '0;
                ld_next_q  <= '0;
            end
            if (ld_size_en) ld_size_q <= mem_rsp_data_i;
            if (ld_next_en) ld_next_q <= mem_rsp_data_i;
        end
    end

    // Next-state logic. step_q selects the first or second access of an op;
    // for LOCK, step 0 is the probe read and step 1 is the CAS.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        step_d     = step_q;
        fail       = 1'b0;
        ld_size_en = 1'b0;
        ld_next_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (core_req_val_i) begin
                    step_d = 1'b0;
                    if (op_is_legal(core_req_op_i)) begin
                        state_d  = S_ISSUE;
                        status_d = STATUS_OK;
                    end else begin
                        state_d  = S_RSP;
                        status_d = STATUS_ILLEGAL_OP;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_rdy_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_val_i) begin
                    case (op_q)
                        OP_LOCK: begin
                            if (mem_rsp_data_i == EMPTY_KEY) begin
                                if (!step_q) begin
                                    step_d  = 1'b1;
                                    state_d = S_ISSUE;
                                end else begin
                                    state_d = S_RSP;
                                end
                            end else begin
                                fail   = 1'b1;
                                step_d = 1'b0;
                                if (limit_hit) begin
                                    state_d  = S_RSP;
                                    status_d = STATUS_LOCK_FAIL;
                                end else begin
                                    state_d = S_BACKOFF;
                                end
                            end
                        end
                        OP_LOAD: begin
                            if (!step_q) begin
                                ld_size_en = 1'b1;
                                step_d     = 1'b1;
                                state_d    = S_ISSUE;
                            end else begin
                                ld_next_en = 1'b1;
                                state_d    = S_RSP;
                            end
                        end
                        OP_INSERT: begin
                            if (!step_q) begin
                                step_d  = 1'b1;
                                state_d = S_ISSUE;
                            end else begin
                                state_d = S_RSP;
                            end
                        end
                        default: state_d = S_RSP;
                    endcase
                end
            end
            S_BACKOFF: begin
                if (backoff_done) state_d = S_ISSUE;
            end
            S_RSP: begin
                if (core_rsp_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory request decode. Everything is a function of registered state,
    // so the request stays stable while mem_req_rdy_i is low.
    always_comb begin
        mem_req_val_o      = 1'b0;
        mem_req_is_write_o = 1'b0;
        mem_req_is_cas_o   = 1'b0;
        mem_req_addr_o     = '0;
        mem_req_data_o     = '0;
        mem_req_cas_exp_o  = '0;
        if (state_q == S_ISSUE) begin
            mem_req_val_o = 1'b1;
            case (op_q)
                OP_LOCK: begin
                    mem_req_addr_o = LOCK_ADDR;
                    if (step_q) begin
                        mem_req_is_cas_o  = 1'b1;
                        mem_req_data_o    = LOCK_ID;
                        mem_req_cas_exp_o = EMPTY_KEY;
                    end
                end
                OP_UNLOCK: begin
                    mem_req_is_write_o = 1'b1;
                    mem_req_addr_o     = LOCK_ADDR;
                    mem_req_data_o     = EMPTY_KEY;
                end
                OP_LOAD: begin
                    mem_req_addr_o = step_q ? (addr_q + NEXT_ADDR_OFFSET) : addr_q;
                end
                OP_INSERT: begin
                    mem_req_is_write_o = 1'b1;
                    mem_req_addr_o     = step_q ? (addr_q + NEXT_ADDR_OFFSET) : addr_q;
                    mem_req_data_o     = step_q ? req_next_q : req_size_q;
                end
                OP_DELETE: begin
                    mem_req_is_write_o = 1'b1;
                    mem_req_addr_o     = addr_q + NEXT_ADDR_OFFSET;
                    mem_req_data_o     = req_next_q;
                end
                default: mem_req_val_o = 1'b0;
            endcase
        end
    end

    // IDLE also accepts memory responses so a late one from an abandoned
    // operation is drained instead of stalling the memory side.
    assign core_req_rdy_o       = (state_q == S_IDLE);
    assign mem_rsp_rdy_o        = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign core_rsp_val_o       = (state_q == S_RSP);
    assign core_rsp_addr_o      = core_rsp_val_o ? addr_q : '0;
    assign core_rsp_size_o      = (core_rsp_val_o && op_q == OP_LOAD) ? ld_size_q : '0;
    assign core_rsp_next_addr_o = (core_rsp_val_o && op_q == OP_LOAD) ? ld_next_q : '0;
    assign core_rsp_status_o    = core_rsp_val_o ? status_q : STATUS_OK;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_falafel_hdr_lsu.sv
`timescale 1ns/1ps
module tb_falafel_hdr_lsu;
    import falafel_pkg::*;

    localparam int unsigned DW   = 64;
    localparam int unsigned MAXR = 4;
    localparam int          W    = 194;

    logic          clk, rst_ni;
    logic          core_req_val_i, core_req_rdy_o;
    logic [2:0]    core_req_op_i;
    logic [DW-1:0] core_req_addr_i, core_req_size_i, core_req_next_addr_i;
    logic          core_rsp_val_o, core_rsp_rdy_i;
    logic [DW-1:0] core_rsp_addr_o, core_rsp_size_o, core_rsp_next_addr_o;
    logic [1:0]    core_rsp_status_o;
    logic          mem_req_val_o, mem_req_rdy_i, mem_req_is_write_o, mem_req_is_cas_o;
    logic [DW-1:0] mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o;
    logic          mem_rsp_val_i, mem_rsp_rdy_o;
    logic [DW-1:0] mem_rsp_data_i;
    lsu_state_e    dbg_state;

    falafel_hdr_lsu #(.DATA_W(DW), .MAX_RETRY(MAXR), .BACKOFF_MAX_LOG2(6)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_req_val_i(core_req_val_i), .core_req_rdy_o(core_req_rdy_o),
        .core_req_op_i(core_req_op_i), .core_req_addr_i(core_req_addr_i),
        .core_req_size_i(core_req_size_i), .core_req_next_addr_i(core_req_next_addr_i),
        .core_rsp_val_o(core_rsp_val_o), .core_rsp_rdy_i(core_rsp_rdy_i),
        .core_rsp_addr_o(core_rsp_addr_o), .core_rsp_size_o(core_rsp_size_o),
        .core_rsp_next_addr_o(core_rsp_next_addr_o), .core_rsp_status_o(core_rsp_status_o),
        .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i),
        .mem_req_is_write_o(mem_req_is_write_o), .mem_req_is_cas_o(mem_req_is_cas_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_cas_exp_o(mem_req_cas_exp_o),
        .mem_rsp_val_i(mem_rsp_val_i), .mem_rsp_rdy_o(mem_rsp_rdy_o),
        .mem_rsp_data_i(mem_rsp_data_i), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];      // expected core responses
    logic [W-1:0] mem_exp_q[$];  // expected memory requests
    logic [63:0]  mem [logic [63:0]];
    logic [63:0]  rd_script[$];  // forced read data for the lock word
    logic [63:0]  cas_script[$]; // forced old word for CAS on the lock word
    int           rsp_delay = 1;
    int           bo_runs[$];
    int           bo_run = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rsp(input logic [63:0] a, input logic [63:0] s,
                                         input logic [63:0] n, input lsu_status_e st);
        return {a, s, n, 2'(st)};
    endfunction

    function automatic logic [W-1:0] mreq(input logic w, input logic c, input logic [63:0] a,
                                          input logic [63:0] d, input logic [63:0] e);
        return {w, c, a, d, e};
    endfunction

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    // ---------------- memory agent ----------------
    initial begin : mem_agent
        logic [63:0] a, d, e, rdata;
        logic        w, c;
        mem_rsp_val_i  = 1'b0;
        mem_rsp_data_i = '0;
        forever begin
            @(negedge clk);
            if (rst_ni && mem_req_val_o && mem_req_rdy_i) begin
                w = mem_req_is_write_o; c = mem_req_is_cas_o;
                a = mem_req_addr_o; d = mem_req_data_o; e = mem_req_cas_exp_o;
                if (mem_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL mem_unexpected: got %0h expected none", mreq(w, c, a, d, e));
                end else begin
                    check("mem_req", mreq(w, c, a, d, e), mem_exp_q.pop_front());
                end
                rdata = '0;
                if (w) begin
                    mem[a] = d;
                end else if (c) begin
                    if (a == 64'd0 && cas_script.size() > 0) rdata = cas_script.pop_front();
                    else begin
                        rdata = rd(a);
                        if (rdata == e) mem[a] = d;
                    end
                end else begin
                    if (a == 64'd0 && rd_script.size() > 0) rdata = rd_script.pop_front();
                    else rdata = rd(a);
                end
                @(posedge clk);
                for (int i = 1; i < rsp_delay; i++) @(posedge clk);
                #1;
                mem_rsp_val_i  = 1'b1;
                mem_rsp_data_i = rdata;
                @(posedge clk);
                #1;
                mem_rsp_val_i  = 1'b0;
                mem_rsp_data_i = '0;
            end
        end
    end

    // ---------------- core response monitor ----------------
    initial begin : core_mon
        logic [W-1:0] got;
        forever begin
            @(negedge clk);
            if (rst_ni && core_rsp_val_o && core_rsp_rdy_i) begin
                got = {core_rsp_addr_o, core_rsp_size_o, core_rsp_next_addr_o, core_rsp_status_o};
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL core_unexpected: got %0h expected none", got);
                end else begin
                    check("core_rsp", got, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- backoff length monitor ----------------
    initial begin : bo_mon
        forever begin
            @(negedge clk);
            if (dbg_state == S_BACKOFF) bo_run++;
            else if (bo_run > 0) begin
                bo_runs.push_back(bo_run);
                bo_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // lat = clock edges from the acceptance edge (inclusive) up to the edge
    // after which core_rsp_val_o is first seen high.
    task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] size,
                        input logic [63:0] nxt, output int lat);
        int n;
        @(posedge clk); #1;
        core_req_val_i = 1'b1; core_req_op_i = op; core_req_addr_i = addr;
        core_req_size_i = size; core_req_next_addr_i = nxt;
        n = 0;
        while (!core_req_rdy_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL req_timeout: got rdy=0 expected rdy=1");
        end
        @(posedge clk); #1;
        core_req_val_i = 1'b0;
        lat = 1;
        while (!core_rsp_val_o && lat < 300) begin @(posedge clk); #1; lat++; end
        if (!core_rsp_val_o) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_timeout: got no response expected one");
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 500 && !(exp_q.size() == 0 && mem_exp_q.size() == 0 && core_req_rdy_o)) begin
            @(negedge clk); n++;
        end
        if (n >= 500) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_drain: got %0d core / %0d mem pending expected 0", name,
                     exp_q.size(), mem_exp_q.size());
            exp_q.delete(); mem_exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int lat, lat_ins, n;
        int exp_bo[3];
`ifdef FALAFEL_LSU_BACKOFF_EN
        exp_bo = '{1, 2, 4};
`else
        exp_bo = '{1, 1, 1};
`endif
        rst_ni = 1'b0;
        core_req_val_i = 1'b0; core_req_op_i = '0; core_req_addr_i = '0;
        core_req_size_i = '0; core_req_next_addr_i = '0;
        core_rsp_rdy_i = 1'b1; mem_req_rdy_i = 1'b1;
        mem[64'h100] = 64'h40;
        mem[64'h108] = 64'h200;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_req_rdy", core_req_rdy_o, 1);
        check("rst_mem_rsp_rdy", mem_rsp_rdy_o, 1);
        check("rst_rsp_val", core_rsp_val_o, 0);
        check("rst_mem_req_val", mem_req_val_o, 0);
        check("rst_rsp_fields", {core_rsp_addr_o, core_rsp_size_o, core_rsp_next_addr_o,
                                 core_rsp_status_o}, '0);
        check("rst_mem_fields", {mem_req_is_write_o, mem_req_is_cas_o, mem_req_addr_o,
                                 mem_req_data_o, mem_req_cas_exp_o}, '0);
        check("rst_state", dbg_state, S_IDLE);
        rst_ni = 1'b1;

        // LOAD 0x100
        mem_exp_q.push_back(mreq(0, 0, 64'h100, 0, 0));
        mem_exp_q.push_back(mreq(0, 0, 64'h108, 0, 0));
        exp_q.push_back(rsp(64'h100, 64'h40, 64'h200, STATUS_OK));
        send(3'd2, 64'h100, 64'h0, 64'h0, lat);
        check("lat_load", lat, 5);
        wait_done("load");

        // INSERT with memory stalled for 3 cycles
        mem_req_rdy_i = 1'b0;
        mem_exp_q.push_back(mreq(1, 0, 64'h100, 64'h20, 0));
        mem_exp_q.push_back(mreq(1, 0, 64'h108, 64'h300, 0));
        exp_q.push_back(rsp(64'h100, 64'h0, 64'h0, STATUS_OK));
        fork
            send(3'd3, 64'h100, 64'h20, 64'h300, lat_ins);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!mem_req_val_o && n < 50);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    check("insert_hold", {mem_req_val_o, mem_req_is_write_o, mem_req_is_cas_o,
                                          mem_req_addr_o, mem_req_data_o},
                          {1'b1, 1'b1, 1'b0, 64'h100, 64'h20});
                end
                @(posedge clk); #1;
                mem_req_rdy_i = 1'b1;
            end
        join
        wait_done("insert");

        // LOAD sees the inserted header
        mem_exp_q.push_back(mreq(0, 0, 64'h100, 0, 0));
        mem_exp_q.push_back(mreq(0, 0, 64'h108, 0, 0));
        exp_q.push_back(rsp(64'h100, 64'h20, 64'h300, STATUS_OK));
        send(3'd2, 64'h100, 64'h0, 64'h0, lat);
        check("lat_load2", lat, 5);
        wait_done("load2");

        // DELETE, plain and with address wrap
        mem_exp_q.push_back(mreq(1, 0, 64'h200, 64'h55, 0));
        exp_q.push_back(rsp(64'h1f8, 64'h0, 64'h0, STATUS_OK));
        send(3'd4, 64'h1f8, 64'h0, 64'h55, lat);
        check("lat_delete", lat, 3);
        wait_done("delete");
        mem_exp_q.push_back(mreq(1, 0, 64'h4, 64'h77, 0));
        exp_q.push_back(rsp(64'hffff_ffff_ffff_fffc, 64'h0, 64'h0, STATUS_OK));
        send(3'd4, 64'hffff_ffff_ffff_fffc, 64'h0, 64'h77, lat);
        check("lat_delete_wrap", lat, 3);
        wait_done("delete_wrap");

        // uncontended LOCK
        mem_exp_q.push_back(mreq(0, 0, 64'h0, 0, 0));
        mem_exp_q.push_back(mreq(0, 1, 64'h0, 64'h1, 64'h0));
        exp_q.push_back(rsp(64'h500, 64'h0, 64'h0, STATUS_OK));
        send(3'd0, 64'h500, 64'h0, 64'h0, lat);
        check("lat_lock", lat, 5);
        wait_done("lock");
        check("lock_word_set", rd(64'h0), 64'h1);

        // UNLOCK
        mem_exp_q.push_back(mreq(1, 0, 64'h0, 64'h0, 0));
        exp_q.push_back(rsp(64'h500, 64'h0, 64'h0, STATUS_OK));
        send(3'd1, 64'h500, 64'h0, 64'h0, lat);
        check("lat_unlock", lat, 3);
        wait_done("unlock");

        // contended LOCK: three busy reads, then success
        bo_runs.delete();
        rd_script = '{64'h7, 64'h7, 64'h7};
        for (int i = 0; i < 4; i++) mem_exp_q.push_back(mreq(0, 0, 64'h0, 0, 0));
        mem_exp_q.push_back(mreq(0, 1, 64'h0, 64'h1, 64'h0));
        exp_q.push_back(rsp(64'h600, 64'h0, 64'h0, STATUS_OK));
        send(3'd0, 64'h600, 64'h0, 64'h0, lat);
        wait_done("lock_contended");
        check("bo_count", bo_runs.size(), 3);
        for (int i = 0; i < 3 && i < bo_runs.size(); i++) check("bo_len", bo_runs[i], exp_bo[i]);

        mem_exp_q.push_back(mreq(1, 0, 64'h0, 64'h0, 0));
        exp_q.push_back(rsp(64'h600, 64'h0, 64'h0, STATUS_OK));
        send(3'd1, 64'h600, 64'h0, 64'h0, lat);
        wait_done("unlock2");

        // LOCK where every CAS loses: MAX_RETRY attempts then LOCK_FAIL
        bo_runs.delete();
        for (int i = 0; i < MAXR; i++) begin
            cas_script.push_back(64'h5);
            mem_exp_q.push_back(mreq(0, 0, 64'h0, 0, 0));
            mem_exp_q.push_back(mreq(0, 1, 64'h0, 64'h1, 64'h0));
        end
        exp_q.push_back(rsp(64'h700, 64'h0, 64'h0, STATUS_LOCK_FAIL));
        send(3'd0, 64'h700, 64'h0, 64'h0, lat);
        wait_done("lock_fail");
        check("fail_bo_count", bo_runs.size(), MAXR - 1);
        check("fail_cas_left", cas_script.size(), 0);

        // illegal op with the core stalling the response
        core_rsp_rdy_i = 1'b0;
        exp_q.push_back(rsp(64'h900, 64'h0, 64'h0, STATUS_ILLEGAL_OP));
        send(3'd6, 64'h900, 64'h11, 64'h22, lat);
        check("lat_illegal", lat, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("illegal_hold", {core_rsp_val_o, mem_req_val_o, core_rsp_addr_o, core_rsp_size_o,
                                   core_rsp_next_addr_o, core_rsp_status_o},
                  {1'b1, 1'b0, 64'h900, 64'h0, 64'h0, 2'd2});
        end
        @(posedge clk); #1;
        core_rsp_rdy_i = 1'b1;
        wait_done("illegal6");
        foreach (exp_bo[i]) begin
            if (i < 2) begin
                exp_q.push_back(rsp(64'ha00, 64'h0, 64'h0, STATUS_ILLEGAL_OP));
                send((i == 0) ? 3'd5 : 3'd7, 64'ha00, 64'h0, 64'h0, lat);
                check("lat_illegal_b", lat, 1);
                wait_done("illegal_b");
            end
        end

        // reset during LOAD WAIT; the late response must be drained
        rsp_delay = 3;
        mem_exp_q.push_back(mreq(0, 0, 64'h100, 0, 0));
        @(posedge clk); #1;
        core_req_val_i = 1'b1; core_req_op_i = 3'd2; core_req_addr_i = 64'h100;
        @(posedge clk); #1;
        core_req_val_i = 1'b0;
        n = 0;
        while (dbg_state != S_WAIT && n < 20) begin @(negedge clk); n++; end
        check("reached_wait", dbg_state, S_WAIT);
        rst_ni = 1'b0;
        #1;
        check("midrst_outputs", {core_req_rdy_o, mem_rsp_rdy_o, core_rsp_val_o, mem_req_val_o},
              4'b1100);
        @(negedge clk);
        rst_ni = 1'b1;
        n = 0;
        while (!mem_rsp_val_i && n < 20) begin @(negedge clk); n++; end
        check("late_rsp_drained", {mem_rsp_val_i, mem_rsp_rdy_o, core_req_rdy_o, dbg_state},
              {1'b1, 1'b1, 1'b1, S_IDLE});
        repeat (3) @(negedge clk);
        check("after_drain_idle", {core_rsp_val_o, dbg_state}, {1'b0, S_IDLE});
        rsp_delay = 1;

        mem_exp_q.push_back(mreq(0, 0, 64'h100, 0, 0));
        mem_exp_q.push_back(mreq(0, 0, 64'h108, 0, 0));
        exp_q.push_back(rsp(64'h100, 64'h20, 64'h300, STATUS_OK));
        send(3'd2, 64'h100, 64'h0, 64'h0, lat);
        check("lat_load_after_rst", lat, 5);
        wait_done("load_after_rst");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/falafel_hdr_lsu.md
# falafel_hdr_lsu

Parametrised successor to the allocator's header load/store unit. It serves one header operation at a time from the falafel core: lock, unlock, load, insert or delete. Each operation becomes a sequence of single-word memory reads, writes or compare-and-swaps (CAS) against the free-list headers. Unlike the first generation, it adds:
- configurable width, offsets and lock identity;
- a proper CAS expected value;
- bounded lock retry with status reporting;
- a valid/ready handshake on the core request.

## Interface
Parameters:
- DATA_W, 64, data and address width.
- NEXT_ADDR_OFFSET, 8, byte offset of the next_addr word from the header base.
- LOCK_ADDR, 0, address of the global lock word.
- LOCK_ID, 1, value written by a successful lock; must differ from EMPTY_KEY.
- EMPTY_KEY, 0, value of a free lock word.
- MAX_RETRY, 16, failed lock attempts before status LOCK_FAIL; 0 means unbounded.
- BACKOFF_MAX_LOG2, 6, log2 of the largest backoff interval in cycles.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset; asynchronous, active-low.
- core_req_val_i, in, 1, request valid.
- core_req_rdy_o, out, 1, LSU can accept a request.
- core_req_op_i, in, 3, lsu_op_e: LOCK=0, UNLOCK=1, LOAD=2, INSERT=3, DELETE=4.
- core_req_addr_i, in, DATA_W, header base address.
- core_req_size_i, in, DATA_W, size to store (INSERT).
- core_req_next_addr_i, in, DATA_W, next_addr to store (INSERT, DELETE).
- core_rsp_val_o, out, 1, response valid.
- core_rsp_rdy_i, in, 1, core accepts the response.
- core_rsp_addr_o, out, DATA_W, echoed request address.
- core_rsp_size_o, out, DATA_W, loaded size (LOAD only; otherwise 0).
- core_rsp_next_addr_o, out, DATA_W, loaded next_addr (LOAD only; otherwise 0).
- core_rsp_status_o, out, 2, OK=0, LOCK_FAIL=1, ILLEGAL_OP=2.
- mem_req_val_o, out, 1, memory request valid.
- mem_req_rdy_i, in, 1, memory accepts the request.
- mem_req_is_write_o, out, 1, 1 = write, 0 = read.
- mem_req_is_cas_o, out, 1, CAS request (is_write_o is 0 during a CAS).
- mem_req_addr_o, out, DATA_W, request address.
- mem_req_data_o, out, DATA_W, write data or CAS swap value.
- mem_req_cas_exp_o, out, DATA_W, CAS expected value.
- mem_rsp_val_i, in, 1, memory response valid.
- mem_rsp_rdy_o, out, 1, LSU accepts the response.
- mem_rsp_data_i, in, DATA_W, read data, or the old word for a CAS.

## Operation
- States: IDLE, ISSUE, WAIT, BACKOFF, RSP.
- IDLE: core_req_rdy_o=1 and mem_rsp_rdy_o=1. Stray memory responses are drained and discarded. A core request is captured on val&rdy.
- ISSUE: drives the current step's memory request and holds it stable until mem_req_rdy_i, then goes to WAIT.
- WAIT: mem_rsp_rdy_o=1. On mem_rsp_val_i the LSU consumes the data and either moves to the next step or goes to RSP/BACKOFF.
- Step sequences:
  - LOCK: read LOCK_ADDR. If the word equals EMPTY_KEY, issue CAS(addr=LOCK_ADDR, exp=EMPTY_KEY, data=LOCK_ID). The CAS succeeds iff the returned old word equals EMPTY_KEY. A non-empty read or a failed CAS is a failed attempt.
  - UNLOCK: write EMPTY_KEY to LOCK_ADDR.
  - LOAD: read addr into size, then read addr+NEXT_ADDR_OFFSET into next_addr.
  - INSERT: write size to addr, then write next_addr to addr+NEXT_ADDR_OFFSET.
  - DELETE: write next_addr to addr+NEXT_ADDR_OFFSET.
- Failed attempt:
  - Increment retry_cnt.
  - If MAX_RETRY≠0 and retry_cnt==MAX_RETRY, go to RSP with LOCK_FAIL.
  - Otherwise go to BACKOFF, then restart the LOCK read.
- Illegal op (>4): no memory traffic; go to RSP with ILLEGAL_OP.
- RSP: hold all core_rsp_* outputs stable until core_rsp_rdy_i, then go to IDLE. The response is not combinationally dependent on core_rsp_rdy_i.
- Address arithmetic is modulo 2^DATA_W (wraps silently).

## Timing
- Reset: all outputs 0, except core_req_rdy_o=1 and mem_rsp_rdy_o=1. State is IDLE; counters and captured fields are 0.
- Reset asserted mid-operation: the operation is abandoned. Any lock held stays held; this is software's responsibility. A late response arriving in IDLE is drained.
- Latency with mem_req_rdy_i=1 and the response one cycle after acceptance: core_rsp_val_o rises 2N+1 cycles after request acceptance, where N is the number of memory accesses. LOAD=5, INSERT=5, DELETE=3, UNLOCK=3, uncontended LOCK=5, ILLEGAL_OP=1.
- No new request is accepted while busy; core_req_rdy_o=0 outside IDLE.
- mem_req_val_o is never asserted in WAIT, BACKOFF or RSP; at most one memory access is outstanding.

## Configuration
- FALAFEL_LSU_BACKOFF_EN defined:
  - BACKOFF waits 2^k cycles, where k = min(retry_cnt-1, BACKOFF_MAX_LOG2).
  - The interval doubles per failure and saturates.
- Undefined: BACKOFF lasts exactly 1 cycle; the backoff counter is not instantiated.

## Structure
- falafel_pkg holds lsu_op_e, lsu_status_e, the state enum and the default constants EMPTY_KEY and NEXT_ADDR_OFFSET.
- One sub-module, falafel_lsu_backoff: holds the retry counter and backoff timer. Interface: start/fail pulse in, done/limit_hit out, clear in.

## Test plan
- LOAD addr=0x100, memory holds 0x40 at 0x100 and 0x200 at 0x108 → reads of 0x100 then 0x108; response size=0x40, next_addr=0x200, status OK, 5 cycles.
- INSERT addr=0x100, size=0x20, next=0x300 with mem_req_rdy_i low for 3 cycles → request held stable; writes to 0x100 then 0x108; status OK.
- LOCK with the lock word=7 for 3 reads, then 0 → 3 backoffs of 1, 2 and 4 cycles (with BACKOFF_EN); CAS exp=0, data=1; status OK.
- LOCK with MAX_RETRY=2 and the CAS returning 5 on every attempt → exactly 2 CAS requests, then status LOCK_FAIL.
- op=6 → no mem_req_val_o; status ILLEGAL_OP after 1 cycle; core_rsp_rdy_i held low for 4 cycles → response held stable.
- rst_ni asserted during a LOAD WAIT, then a response arrives after reset → response drained; next request completes normally.
